// File: rtl/systolic_2x2_stream_ctrl.sv
// Streaming front/back-end for the 2x2 systolic array.
// Accepted rows drive the array inputs, a tag pipe matched to the array latency
// marks when aligned results arrive, and those results are captured into an
// output FIFO. Credit admission keeps in-flight rows plus FIFO entries within
// OUT_DEPTH, so a capture always finds space.
// Optional perf counters: define SYSTOLIC_STREAM_PERF_EN.
module systolic_2x2_stream_ctrl #(
  parameter int unsigned A_W       = 4,
  parameter int unsigned C_W       = 8,
  parameter int unsigned ARRAY_LAT = 3,  // must be >= 1
  parameter int unsigned OUT_DEPTH = 8   // must be >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [A_W-1:0] s_a0,
  input  logic signed [A_W-1:0] s_a1,
  input  logic                  s_last,
  output logic signed [A_W-1:0] a_row0_out,
  output logic signed [A_W-1:0] a_row1_out,
  input  logic signed [C_W-1:0] c_col0_in,
  input  logic signed [C_W-1:0] c_col1_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [C_W-1:0] m_c0,
  output logic signed [C_W-1:0] m_c1,
  output logic                  m_last,
  output logic [15:0]           perf_rows,
  output logic [15:0]           perf_stall
);

  localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SumW = $clog2(OUT_DEPTH + ARRAY_LAT + 2);
  localparam int unsigned EntW = 2 * C_W + 1;

  logic                  accept, push, pop;
  logic [SumW-1:0]       occupancy;
  logic signed [A_W-1:0] a_row0_d, a_row0_q, a_row1_d, a_row1_q;
  logic [ARRAY_LAT:0]    tag_vld_d, tag_vld_q, tag_last_d, tag_last_q;
  logic [EntW-1:0]       mem_d [OUT_DEPTH];
  logic [EntW-1:0]       mem_q [OUT_DEPTH];
  logic [PtrW-1:0]       wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0]       count_d, count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit: FIFO entries plus rows still in flight must stay below the depth
  always_comb begin
    occupancy = SumW'(count_q) + SumW'($countones(tag_vld_q));
    s_ready   = (occupancy < SumW'(OUT_DEPTH));
    accept    = s_valid & s_ready;
    m_valid   = (count_q != '0);
    pop       = m_valid & m_ready;
    push      = tag_vld_q[ARRAY_LAT];
    {m_c0, m_c1, m_last} = mem_q[rd_ptr_q];
  end

  // Array drive (bubble of zeros when nothing is accepted) and tag pipe shift
  always_comb begin
    a_row0_d   = accept ? s_a0 : '0;
    a_row1_d   = accept ? s_a1 : '0;
    tag_vld_d  = {tag_vld_q[ARRAY_LAT-1:0], accept};
    tag_last_d = {tag_last_q[ARRAY_LAT-1:0], s_last};
  end

  // Output FIFO next state: unconditional capture on a final-stage tag
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {c_col0_in, c_col1_in, tag_last_q[ARRAY_LAT]};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_row0_q   <= '0;
      a_row1_q   <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      a_row0_q   <= a_row0_d;
      a_row1_q   <= a_row1_d;
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign a_row0_out = a_row0_q;
  assign a_row1_out = a_row1_q;

`ifdef SYSTOLIC_STREAM_PERF_EN
  logic [15:0] perf_rows_d, perf_rows_q, perf_stall_d, perf_stall_q;

  // Row counter wraps; stall counter saturates
  always_comb begin
    perf_rows_d  = perf_rows_q + 16'(accept);
    perf_stall_d = perf_stall_q;
    if (s_valid && !s_ready && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rows_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_rows_q  <= perf_rows_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_rows  = perf_rows_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_rows  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_systolic_2x2_stream_ctrl.sv
// Self-checking bench for systolic_2x2_stream_ctrl.
// Includes a 2x2 array stand-in (weights 1,2,3,4, fixed latency) and a
// queue-based reference model of row admission, result order and timing.
module tb_systolic_2x2_stream_ctrl;

  localparam int A_W   = 4;
  localparam int C_W   = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic signed [A_W-1:0] s_a0 = '0, s_a1 = '0, a_row0_out, a_row1_out;
  logic signed [C_W-1:0] c_col0_in, c_col1_in, m_c0, m_c1;
  logic                  m_valid, m_ready = 1'b0, m_last;
  logic [15:0]           perf_rows, perf_stall;

  systolic_2x2_stream_ctrl #(
    .A_W(A_W), .C_W(C_W), .ARRAY_LAT(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a0(s_a0), .s_a1(s_a1), .s_last(s_last),
    .a_row0_out(a_row0_out), .a_row1_out(a_row1_out),
    .c_col0_in(c_col0_in), .c_col1_in(c_col1_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_c0(m_c0), .m_c1(m_c1), .m_last(m_last),
    .perf_rows(perf_rows), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // Array stand-in: C = A x W with W00=1, W01=2, W10=3, W11=4, LAT edges deep
  logic signed [C_W-1:0] arr0 [LAT];
  logic signed [C_W-1:0] arr1 [LAT];
  always @(posedge clk) begin
    arr0[0] <= C_W'(int'(a_row0_out) + 3 * int'(a_row1_out));
    arr1[0] <= C_W'(2 * int'(a_row0_out) + 4 * int'(a_row1_out));
    for (int i = 1; i < LAT; i++) begin
      arr0[i] <= arr0[i-1];
      arr1[i] <= arr1[i-1];
    end
  end
  assign c_col0_in = arr0[LAT-1];
  assign c_col1_in = arr1[LAT-1];

  // Reference model state
  typedef struct {
    logic signed [C_W-1:0] c0;
    logic signed [C_W-1:0] c1;
    logic                  last;
    int                    rdy;
  } res_t;

  res_t                  exp_q[$];
  int                    cyc = 0, acc_tot = 0, pop_tot = 0;
  int                    n_cmp = 0, n_fail = 0;
  logic signed [A_W-1:0] exp_a0 = '0, exp_a1 = '0;
  logic [15:0]           m_rows = '0, m_stall = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge
  task automatic tick();
    logic exp_ready, exp_mvalid, acc, pop_e;
    @(negedge clk);
    exp_ready  = (acc_tot - pop_tot) < DEPTH;
    exp_mvalid = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
    check("s_ready", 32'(s_ready), 32'(exp_ready));
    check("m_valid", 32'(m_valid), 32'(exp_mvalid));
    check("a_row0", 32'(a_row0_out), 32'(exp_a0));
    check("a_row1", 32'(a_row1_out), 32'(exp_a1));
    if (exp_mvalid) begin
      check("m_c0", 32'(m_c0), 32'(exp_q[0].c0));
      check("m_c1", 32'(m_c1), 32'(exp_q[0].c1));
      check("m_last", 32'(m_last), 32'(exp_q[0].last));
    end
`ifdef SYSTOLIC_STREAM_PERF_EN
    check("perf_rows", 32'(perf_rows), 32'(m_rows));
    check("perf_stall", 32'(perf_stall), 32'(m_stall));
`else
    check("perf_rows", 32'(perf_rows), 32'd0);
    check("perf_stall", 32'(perf_stall), 32'd0);
`endif
    acc   = s_valid && exp_ready;
    pop_e = exp_mvalid && m_ready;
    @(posedge clk);
    cyc++;
    if (pop_e) begin
      void'(exp_q.pop_front());
      pop_tot++;
    end
    if (acc) begin
      exp_q.push_back('{c0: C_W'(int'(s_a0) + 3 * int'(s_a1)),
                        c1: C_W'(2 * int'(s_a0) + 4 * int'(s_a1)),
                        last: s_last, rdy: cyc + LAT + 1});
      acc_tot++;
    end
    exp_a0  = acc ? s_a0 : '0;
    exp_a1  = acc ? s_a1 : '0;
    m_rows  = m_rows + 16'(acc);
    if (s_valid && !exp_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
    #1;
  endtask

  // Asynchronous reset asserted away from the clock edge
  task automatic do_reset();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_c0", 32'(m_c0), 32'd0);
    check("rst_m_c1", 32'(m_c1), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_a_row0", 32'(a_row0_out), 32'd0);
    check("rst_perf_rows", 32'(perf_rows), 32'd0);
    check("rst_perf_stall", 32'(perf_stall), 32'd0);
    exp_q.delete();
    acc_tot = 0;
    pop_tot = 0;
    exp_a0  = '0;
    exp_a1  = '0;
    m_rows  = '0;
    m_stall = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drive_row(input int a0, input int a1, input logic last);
    s_valid = 1'b1;
    s_a0    = A_W'(a0);
    s_a1    = A_W'(a1);
    s_last  = last;
  endtask

  task automatic drive_rand();
    s_a0   = A_W'($urandom);
    s_a1   = A_W'($urandom);
    s_last = 1'($urandom);
  endtask

  initial begin
    #2;
    do_reset();

    // Single row (1,2) -> (7,10) five cycles later
    m_ready = 1'b1;
    drive_row(1, 2, 1'b0);
    tick();
    s_valid = 1'b0;
    repeat (8) tick();

    // Back-to-back rows, last on the third
    drive_row(1, 2, 1'b0);
    tick();
    drive_row(3, -1, 1'b0);
    tick();
    drive_row(-8, -8, 1'b1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (8) tick();

    // Backpressure: only DEPTH rows admitted, nothing lost
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    repeat (20) begin
      drive_rand();
      tick();
    end
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    check("bp_accepted", 32'(acc_tot), 32'(DEPTH));
`ifdef SYSTOLIC_STREAM_PERF_EN
    check("bp_perf_rows", 32'(perf_rows), 32'd8);
    check("bp_perf_stall", 32'(perf_stall), 32'd12);
`else
    check("bp_perf_rows", 32'(perf_rows), 32'd0);
    check("bp_perf_stall", 32'(perf_stall), 32'd0);
`endif
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (12) tick();

    // Fill to DEPTH-1, then push and pop together
    m_ready = 1'b0;
    s_valid = 1'b1;
    repeat (DEPTH - 1) begin
      drive_rand();
      tick();
    end
    s_valid = 1'b0;
    repeat (6) tick();
    m_ready = 1'b1;
    s_valid = 1'b1;
    repeat (12) begin
      drive_rand();
      tick();
    end
    s_valid = 1'b0;
    repeat (14) tick();

    // Random traffic with random backpressure
    repeat (300) begin
      s_valid = ($urandom_range(3) != 0);
      m_ready = 1'($urandom);
      drive_rand();
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (16) tick();

    // Mid-flight reset with three rows in flight
    s_last = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      s_a0 = A_W'($urandom);
      s_a1 = A_W'($urandom);
      tick();
    end
    do_reset();
    m_ready = 1'b1;
    drive_row(1, 2, 1'b0);
    tick();
    s_valid = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
